// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding seen by the decoder, sequencer
// state encoding and instruction field layout.
package alu_pkg;

  // Opcodes carried in instr[7:5]
  localparam logic [2:0] OP_SUMA   = 3'h0;
  localparam logic [2:0] OP_COMPL  = 3'h1;
  localparam logic [2:0] OP_SHR    = 3'h2;
  localparam logic [2:0] OP_SHL    = 3'h3;
  localparam logic [2:0] OP_COMPC  = 3'h4;
  localparam logic [2:0] OP_COMPN  = 3'h5;
  localparam logic [2:0] OP_SAVE   = 3'h6;
  localparam logic [2:0] OP_LOAD   = 3'h7;

  // Instruction field positions
  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPR_W   = 5;

  // Watchdog limit (cycles in ISSUE without an acknowledge)
  localparam int WD_CNT_W = 4;
  localparam int WD_LIMIT = 15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_ISSUE = 3'd3,
    S_NEXT  = 3'd4
  } seq_state_e;

  function automatic logic [2:0] get_opc(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// Cycle counter for the ISSUE wait. Cleared while i_clear is high, counts
// while i_en is high, flags o_expire on the LIMIT-th counted cycle.
module alu_seq_watchdog #(
  parameter int CNT_W = 4,
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles, saturating at the expiry value
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_en && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer feeding the ALU opcode decoder. Fetches from a
// synchronous ROM, latches into ir, holds each op until alu_done, then
// advances pc until PROG_LEN instructions have run.
// Optional ISSUE watchdog with sticky error: define ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PROG_LEN = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [2:0]         address,
  output logic [OPR_W-1:0]   operand,
  output logic               op_valid,
  input  logic               alu_done,
  output logic               busy,
  output logic               run_done,
  output logic               error
);

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

  seq_state_e         r_state, w_next;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic               r_busy, r_run_done;
  logic               w_start, w_wd_expire;

  // stop outranks start in IDLE
  assign w_start = start && !stop;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic r_error;

  alu_seq_watchdog #(.CNT_W(WD_CNT_W), .LIMIT(WD_LIMIT)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (r_state != S_ISSUE),
    .i_en     (r_state == S_ISSUE),
    .o_expire (w_wd_expire)
  );

  // Sticky timeout flag, cleared by a fresh start
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_error <= 1'b0;
    else if (r_state == S_IDLE && w_start)
      r_error <= 1'b0;
    else if (r_state == S_ISSUE && w_wd_expire && !alu_done && !stop)
      r_error <= 1'b1;
  end

  assign error = r_error;
`else
  assign w_wd_expire = 1'b0;
  assign error       = 1'b0;
`endif

  // Next-state logic; stop forces IDLE from any active state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_FETCH;
      S_FETCH: w_next = S_LATCH;
      S_LATCH: w_next = S_ISSUE;
      S_ISSUE: begin
        if (alu_done)         w_next = S_NEXT;
        else if (w_wd_expire) w_next = S_IDLE;
      end
      S_NEXT:  w_next = (r_pc == LAST_PC) ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase
    if (stop && r_state != S_IDLE) w_next = S_IDLE;
  end

  // State, pc, ir and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_busy     <= 1'b0;
      r_run_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != S_IDLE);
      // high for exactly the NEXT cycle of the final instruction
      r_run_done <= (w_next == S_NEXT) && (r_pc == LAST_PC);
      // every path back to IDLE rewinds pc, so a new run starts at 0
      if (w_next == S_IDLE || r_state == S_IDLE) r_pc <= '0;
      else if (r_state == S_NEXT)                r_pc <= r_pc + 1'b1;
      // ROM data is valid in LATCH; an aborted latch keeps the old ir
      if (r_state == S_LATCH && w_next == S_ISSUE) r_ir <= imem_rdata;
    end
  end

  assign imem_addr = r_pc;
  assign address   = get_opc(r_ir);
  assign operand   = r_ir[OPR_W-1:0];
  assign op_valid  = (r_state == S_ISSUE);
  assign busy      = r_busy;
  assign run_done  = r_run_done;

endmodule
